// File: rtl/seq_pkg.sv
// seq_pkg: shared definitions for the CPU control sequencer.
//   - seq_state_t   : sequencer state enumeration (S_PAUSE only when
//                     SEQ_SINGLE_STEP_EN is defined)
//   - STP_OPCODE    : instr[15:9] value of the STP (halt) instruction
//   - CNT_W_DEFAULT : default width of the debug counters
//   - PH_*          : one-hot phase encoding {EXEC2, EXEC1, FETCH}, shared
//                     with the decoder bench
package seq_pkg;

  localparam int         CNT_W_DEFAULT = 32;
  localparam logic [6:0] STP_OPCODE    = 7'b0111111;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC1 = 3'd2,
    S_EXEC2 = 3'd3,
`ifdef SEQ_SINGLE_STEP_EN
    S_PAUSE = 3'd5,
`endif
    S_HALT  = 3'd4
  } seq_state_t;

  localparam logic [2:0] PH_NONE  = 3'b000;
  localparam logic [2:0] PH_FETCH = 3'b001;
  localparam logic [2:0] PH_EXEC1 = 3'b010;
  localparam logic [2:0] PH_EXEC2 = 3'b100;

  // Phase strobes implied by a state; idle, halt and pause drive none.
  function automatic logic [2:0] phase_of(input seq_state_t s);
    logic [2:0] ph;
    case (s)
      S_FETCH: ph = PH_FETCH;
      S_EXEC1: ph = PH_EXEC1;
      S_EXEC2: ph = PH_EXEC2;
      default: ph = PH_NONE;
    endcase
    return ph;
  endfunction

  // True when the instruction word encodes STP.
  function automatic logic is_stp(input logic [15:0] w);
    return (w[15:9] == STP_OPCODE);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: W-bit up counter that sticks at all-ones instead of wrapping.
// Ports:
//   CLK  - clock, counts on the rising edge
//   nRST - asynchronous active-low clear
//   inc  - count enable for this cycle
//   q    - current count
module sat_counter #(
  parameter int W = 32
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] q_r;

  // Count register: increments on inc unless already saturated.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      q_r <= {W{1'b0}};
    end else if (inc && (q_r != {W{1'b1}})) begin
      q_r <= q_r + {{(W-1){1'b0}}, 1'b1};
    end
  end

  assign q = q_r;

endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: FETCH / EXEC1 / [EXEC2] instruction sequencer for the
// 16-bit CPU, with instruction register, STP halt and debug counters.
// Optional feature macro: SEQ_SINGLE_STEP_EN (adds step_mode/step ports and
// a PAUSE state entered after each retired instruction in step mode).
// Ports:
//   CLK, nRST        - clock, asynchronous active-low reset
//   run              - start request, looked at only in IDLE
//   instr_in/valid   - word from instruction RAM, captured in FETCH
//   E2               - decoder request for a second execute cycle (EXEC1)
//   step_mode, step  - single-step controls (SEQ_SINGLE_STEP_EN only)
//   FETCH/EXEC1/EXEC2- registered one-hot phase strobes
//   instr            - instruction register feeding the decoder
//   halted           - high while in HALT
//   cycle_count      - saturating count of FETCH/EXEC1/EXEC2 cycles
//   retired_count    - saturating count of completed instructions
module cpu_sequencer
  import seq_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             run,
  input  logic [15:0]      instr_in,
  input  logic             instr_valid,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic             step_mode,
  input  logic             step,
`endif
  input  logic             E2,
  output logic             FETCH,
  output logic             EXEC1,
  output logic             EXEC2,
  output logic [15:0]      instr,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] retired_count
);

  seq_state_t  state_r;
  seq_state_t  state_nxt_s;
  seq_state_t  resume_state_s;
  logic [2:0]  phase_r;
  logic        halted_r;
  logic [15:0] instr_r;
  logic        instr_load_s;
  logic        retire_s;
  logic        busy_s;

  // Where a retired (non-STP) instruction goes next.
`ifdef SEQ_SINGLE_STEP_EN
  assign resume_state_s = step_mode ? S_PAUSE : S_FETCH;
`else
  assign resume_state_s = S_FETCH;
`endif

  // Next-state, instruction-capture and retire decode.
  always_comb begin
    state_nxt_s  = state_r;
    instr_load_s = 1'b0;
    retire_s     = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (run) begin
          state_nxt_s = S_FETCH;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_FETCH: begin
        if (instr_valid) begin
          instr_load_s = 1'b1;
          state_nxt_s  = S_EXEC1;
        end else begin
          state_nxt_s  = S_FETCH;
        end
      end
      S_EXEC1: begin
        // STP wins over E2 so a halting instruction never gets an EXEC2.
        if (is_stp(instr_r)) begin
          retire_s    = 1'b1;
          state_nxt_s = S_HALT;
        end else if (E2) begin
          state_nxt_s = S_EXEC2;
        end else begin
          retire_s    = 1'b1;
          state_nxt_s = resume_state_s;
        end
      end
      S_EXEC2: begin
        retire_s    = 1'b1;
        state_nxt_s = resume_state_s;
      end
      S_HALT: begin
        state_nxt_s = S_HALT;
      end
`ifdef SEQ_SINGLE_STEP_EN
      S_PAUSE: begin
        if (step || !step_mode) begin
          state_nxt_s = S_FETCH;
        end else begin
          state_nxt_s = S_PAUSE;
        end
      end
`endif
      default: begin
        state_nxt_s = S_IDLE;
      end
    endcase
  end

  // State, strobes and halt flag; strobes are registered from the next state
  // so they come straight off flops and always match state_r.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_r  <= S_IDLE;
      phase_r  <= PH_NONE;
      halted_r <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      phase_r  <= phase_of(state_nxt_s);
      halted_r <= (state_nxt_s == S_HALT);
    end
  end

  // Instruction register: changes only on a FETCH capture.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      instr_r <= 16'h0000;
    end else if (instr_load_s) begin
      instr_r <= instr_in;
    end
  end

  assign busy_s = |phase_r;

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .CLK  (CLK),
    .nRST (nRST),
    .inc  (busy_s),
    .q    (cycle_count)
  );

  sat_counter #(.W(CNT_W)) u_retired_cnt (
    .CLK  (CLK),
    .nRST (nRST),
    .inc  (retire_s),
    .q    (retired_count)
  );

  assign FETCH  = phase_r[0];
  assign EXEC1  = phase_r[1];
  assign EXEC2  = phase_r[2];
  assign instr  = instr_r;
  assign halted = halted_r;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed-vector bench with a scoreboard. Each vector
// queues the outputs expected after the next clock edge; a monitor pops and
// compares on the falling edge. Reset checks are made directly. A second
// instance with 3-bit counters exercises saturation.
module tb_cpu_sequencer;

  localparam logic [2:0] F  = 3'b100;  // {FETCH,EXEC1,EXEC2}
  localparam logic [2:0] X1 = 3'b010;
  localparam logic [2:0] X2 = 3'b001;
  localparam logic [2:0] NO = 3'b000;

  // STP is instr[15:9] == 7'b0111111, i.e. 16'h7E00.
  localparam logic [15:0] NOP = 16'h1E00;
  localparam logic [15:0] MUL = 16'h3800;
  localparam logic [15:0] STP = 16'h7E00;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic [15:0] instr_in;
  logic        instr_valid;
  logic        e2;
  logic        fetch, exec1, exec2, halted;
  logic [15:0] instr;
  logic [31:0] cycle_count, retired_count;
  logic        s_fetch, s_exec1, s_exec2, s_halted;
  logic [15:0] s_instr;
  logic [2:0]  s_cc, s_rc;
`ifdef SEQ_SINGLE_STEP_EN
  logic        step_mode, step;
`endif

  typedef struct {
    int          cyc;
    string       nm;
    logic [2:0]  ph;
    logic        h;
    logic [15:0] ins;
    logic [31:0] cc;
    logic [31:0] rc;
  } exp_t;

  exp_t sb[$];
  int   tb_cyc = 0;
  int   n_vec  = 0;
  int   n_err  = 0;

  cpu_sequencer #(.CNT_W(32)) dut (
    .CLK(clk), .nRST(rst_n), .run(run), .instr_in(instr_in),
    .instr_valid(instr_valid),
`ifdef SEQ_SINGLE_STEP_EN
    .step_mode(step_mode), .step(step),
`endif
    .E2(e2), .FETCH(fetch), .EXEC1(exec1), .EXEC2(exec2), .instr(instr),
    .halted(halted), .cycle_count(cycle_count), .retired_count(retired_count)
  );

  cpu_sequencer #(.CNT_W(3)) dut_sat (
    .CLK(clk), .nRST(rst_n), .run(run), .instr_in(instr_in),
    .instr_valid(instr_valid),
`ifdef SEQ_SINGLE_STEP_EN
    .step_mode(step_mode), .step(step),
`endif
    .E2(e2), .FETCH(s_fetch), .EXEC1(s_exec1), .EXEC2(s_exec2), .instr(s_instr),
    .halted(s_halted), .cycle_count(s_cc), .retired_count(s_rc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) tb_cyc <= tb_cyc + 1;

  task automatic chk(input string nm, input logic [2:0] ph, input logic h,
                     input logic [15:0] ins, input logic [31:0] cc, input logic [31:0] rc);
    n_vec++;
    if ({fetch, exec1, exec2} !== ph || halted !== h || instr !== ins ||
        cycle_count !== cc || retired_count !== rc) begin
      n_err++;
      $display("FAIL %s: got ph=%b h=%b instr=%h cyc=%0d ret=%0d, required ph=%b h=%b instr=%h cyc=%0d ret=%0d",
               nm, {fetch, exec1, exec2}, halted, instr, cycle_count, retired_count,
               ph, h, ins, cc, rc);
    end
  endtask

  // Monitor: compare each queued expectation in the cycle it targets.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc < tb_cyc) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: expectation for cycle %0d not checked (now %0d)",
               sb[0].nm, sb[0].cyc, tb_cyc);
      void'(sb.pop_front());
    end
    if (sb.size() > 0 && sb[0].cyc == tb_cyc) begin
      exp_t e;
      e = sb.pop_front();
      chk(e.nm, e.ph, e.h, e.ins, e.cc, e.rc);
    end
  end

  // Drive one cycle of inputs and queue the outputs expected after the edge.
  task automatic vec(input string nm, input logic r, input logic iv, input logic [15:0] ii,
                     input logic e, input logic [2:0] ph, input logic h,
                     input logic [15:0] ins, input logic [31:0] cc, input logic [31:0] rc);
    exp_t x;
    run = r; instr_valid = iv; instr_in = ii; e2 = e;
    x.cyc = tb_cyc + 1; x.nm = nm; x.ph = ph; x.h = h; x.ins = ins; x.cc = cc; x.rc = rc;
    sb.push_back(x);
    @(posedge clk);
    #2;
  endtask

  task automatic chk_sat(input string nm, input logic [2:0] cc, input logic [2:0] rc);
    n_vec++;
    if (s_cc !== cc || s_rc !== rc) begin
      n_err++;
      $display("FAIL %s: got cyc=%0d ret=%0d, required cyc=%0d ret=%0d", nm, s_cc, s_rc, cc, rc);
    end
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; instr_in = 16'h0000; instr_valid = 1'b0; e2 = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
    step_mode = 1'b0; step = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #2;
    chk("reset_state", NO, 1'b0, 16'h0000, 32'd0, 32'd0);
    rst_n = 1'b1;

    // Idle hold, then NOP stream: FETCH/EXEC1 pairs.
    vec("idle_hold", 1'b0, 1'b1, NOP, 1'b0, NO, 1'b0, 16'h0000, 32'd0, 32'd0);
    vec("run_fetch", 1'b1, 1'b1, NOP, 1'b0, F,  1'b0, 16'h0000, 32'd0, 32'd0);
    vec("nop1_e1",   1'b0, 1'b1, NOP, 1'b0, X1, 1'b0, NOP,      32'd1, 32'd0);
    vec("nop1_done", 1'b0, 1'b1, NOP, 1'b0, F,  1'b0, NOP,      32'd2, 32'd1);
    vec("nop2_e1",   1'b0, 1'b1, NOP, 1'b0, X1, 1'b0, NOP,      32'd3, 32'd1);
    vec("nop2_done", 1'b0, 1'b1, NOP, 1'b0, F,  1'b0, NOP,      32'd4, 32'd2);
    vec("nop3_e1",   1'b0, 1'b1, NOP, 1'b0, X1, 1'b0, NOP,      32'd5, 32'd2);
    vec("nop3_done", 1'b0, 1'b1, NOP, 1'b0, F,  1'b0, NOP,      32'd6, 32'd3);

    // Fetch wait: four cycles without valid, instr held.
    for (int i = 0; i < 4; i++)
      vec("fetch_wait", 1'b0, 1'b0, 16'h1234, 1'b0, F, 1'b0, NOP, 32'd7 + i, 32'd3);
    vec("fetch_cap",   1'b0, 1'b1, 16'h1234, 1'b0, X1, 1'b0, 16'h1234, 32'd11, 32'd3);
    vec("wait_done",   1'b0, 1'b0, 16'h0000, 1'b0, F,  1'b0, 16'h1234, 32'd12, 32'd4);

    // E2 path with MUL; run=0 throughout has no effect.
    vec("mul_e1",      1'b0, 1'b1, MUL, 1'b0, X1, 1'b0, MUL, 32'd13, 32'd4);
    vec("mul_e2",      1'b0, 1'b0, MUL, 1'b1, X2, 1'b0, MUL, 32'd14, 32'd4);
    vec("mul_done",    1'b0, 1'b0, MUL, 1'b0, F,  1'b0, MUL, 32'd15, 32'd5);

    // STP with E2 forced high: straight to HALT, counted as retired.
    vec("stp_e1",      1'b0, 1'b1, STP, 1'b1, X1, 1'b0, STP, 32'd16, 32'd5);
    vec("stp_halt",    1'b0, 1'b0, STP, 1'b1, NO, 1'b1, STP, 32'd17, 32'd6);
    vec("halt_run1",   1'b1, 1'b1, NOP, 1'b0, NO, 1'b1, STP, 32'd17, 32'd6);
    vec("halt_run2",   1'b1, 1'b1, NOP, 1'b0, NO, 1'b1, STP, 32'd17, 32'd6);
    @(negedge clk);
    #1;
    chk_sat("sat_counters", 3'd7, 3'd6);
    run = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("reset_from_halt", NO, 1'b0, 16'h0000, 32'd0, 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Reset during EXEC2: partial MUL is not retired.
    vec("r_fetch",     1'b1, 1'b1, MUL, 1'b0, F,  1'b0, 16'h0000, 32'd0, 32'd0);
    vec("r_e1",        1'b0, 1'b1, MUL, 1'b0, X1, 1'b0, MUL,      32'd1, 32'd0);
    vec("r_e2",        1'b0, 1'b0, MUL, 1'b1, X2, 1'b0, MUL,      32'd2, 32'd0);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("reset_mid_exec2", NO, 1'b0, 16'h0000, 32'd0, 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    vec("restart",     1'b1, 1'b1, NOP, 1'b0, F,  1'b0, 16'h0000, 32'd0, 32'd0);

`ifdef SEQ_SINGLE_STEP_EN
    // Single step: PAUSE after each retire until step.
    step_mode = 1'b1;
    vec("ss_e1",       1'b0, 1'b1, NOP, 1'b0, X1, 1'b0, NOP, 32'd1, 32'd0);
    vec("ss_pause",    1'b0, 1'b1, NOP, 1'b0, NO, 1'b0, NOP, 32'd2, 32'd1);
    vec("ss_hold",     1'b0, 1'b1, NOP, 1'b0, NO, 1'b0, NOP, 32'd2, 32'd1);
    step = 1'b1;
    vec("ss_step",     1'b0, 1'b1, NOP, 1'b0, F,  1'b0, NOP, 32'd2, 32'd1);
    step = 1'b0;
    vec("ss_e1b",      1'b0, 1'b1, NOP, 1'b0, X1, 1'b0, NOP, 32'd3, 32'd1);
    vec("ss_pause2",   1'b0, 1'b1, NOP, 1'b0, NO, 1'b0, NOP, 32'd4, 32'd2);
    vec("ss_hold2",    1'b0, 1'b1, NOP, 1'b0, NO, 1'b0, NOP, 32'd4, 32'd2);
`endif

    repeat (2) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
